// File: rtl/struct_seq_gen_pkg.sv
// Shared types for the structured sequence generator.
// pkg1 and pkg2 deliberately both export a type called struct1, so every
// user refers to them with the package prefix and never imports them wholesale.

package pkg1;
    localparam int W1 = 8;

    typedef struct packed {
        logic [W1-1:0] first;
    } struct1;
endpackage

package pkg2;
    localparam int W2 = 7;

    typedef struct packed {
        logic [W2-1:0] second;
    } struct1;
endpackage

package struct_seq_gen_pkg;
    // Burst controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Sequence modes; code 3 is a second spelling of "hold constant"
    typedef enum logic [1:0] {
        MODE_CONST     = 2'd0,
        MODE_INCR      = 2'd1,
        MODE_DECR      = 2'd2,
        MODE_ALT_CONST = 2'd3
    } mode_e;
endpackage

// File: rtl/seq_field_step.sv
// One field of the record: computes either the burst start value or the
// value that follows the current one, for any field width.

module seq_field_step #(
    parameter int W = 8
) (
    input  logic [W-1:0]               value_i,
    input  struct_seq_gen_pkg::mode_e  mode_i,
    input  logic                       load_i,
    output logic [W-1:0]               next_o
);

    // Start value on load (zero when counting up, all-ones otherwise), else one step with natural wrap at W bits
    always_comb begin
        next_o = value_i;
        if (load_i) begin
            if (mode_i == struct_seq_gen_pkg::MODE_INCR) begin
                next_o = '0;
            end else begin
                next_o = '1;
            end
        end else begin
            case (mode_i)
                struct_seq_gen_pkg::MODE_INCR: next_o = value_i + W'(1);
                struct_seq_gen_pkg::MODE_DECR: next_o = value_i - W'(1);
                default:                       next_o = value_i;
            endcase
        end
    end

endmodule

// File: rtl/struct_seq_gen.sv
// Burst generator emitting LEN records of three independently-wrapping fields
// over a valid/ready handshake, followed by a one-cycle done pulse.

module struct_seq_gen #(
    parameter int LEN = 16,
    parameter int W3  = 6
) (
    clk,
    rst_n,
    start,
    mode,
    out_valid,
    out_ready,
    var1,
    var2,
    var3,
    done
);

    // The third field's width is a module parameter, so its record type lives here
    typedef struct packed {
        logic [W3-1:0] third;
    } struct2;

    localparam int             CW        = $clog2(LEN + 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(LEN - 1);

    input  logic         clk;
    input  logic         rst_n;
    input  logic         start;
    input  logic [1:0]   mode;
    output logic         out_valid;
    input  logic         out_ready;
    output pkg1::struct1 var1;
    output pkg2::struct1 var2;
    output struct2       var3;
    output logic         done;

    struct_seq_gen_pkg::state_e state_q, state_d;
    struct_seq_gen_pkg::mode_e  mode_q, mode_d;
    logic [CW-1:0]              beat_q, beat_d;
    logic                       valid_q, valid_d;
    logic                       done_q, done_d;
    pkg1::struct1               var1_q, var1_d;
    pkg2::struct1               var2_q, var2_d;
    struct2                     var3_q, var3_d;

    struct_seq_gen_pkg::mode_e  stepMode;
    logic                       loadField;
    logic                       handshake;
    logic [pkg1::W1-1:0]        nextFirst;
    logic [pkg2::W2-1:0]        nextSecond;
    logic [W3-1:0]              nextThird;

    // In IDLE the steppers produce start values for the incoming mode; in RUN they step with the latched mode
    always_comb begin
        loadField = (state_q == struct_seq_gen_pkg::ST_IDLE);
        stepMode  = loadField ? struct_seq_gen_pkg::mode_e'(mode) : mode_q;
        handshake = valid_q & out_ready;
    end

    seq_field_step #(.W(pkg1::W1)) u_step_first (
        .value_i (var1_q.first),
        .mode_i  (stepMode),
        .load_i  (loadField),
        .next_o  (nextFirst)
    );

    seq_field_step #(.W(pkg2::W2)) u_step_second (
        .value_i (var2_q.second),
        .mode_i  (stepMode),
        .load_i  (loadField),
        .next_o  (nextSecond)
    );

    seq_field_step #(.W(W3)) u_step_third (
        .value_i (var3_q.third),
        .mode_i  (stepMode),
        .load_i  (loadField),
        .next_o  (nextThird)
    );

    // Next-state logic: start a burst, advance fields on each accepted beat, and pulse done after the last one
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        var1_d  = var1_q;
        var2_d  = var2_q;
        var3_d  = var3_q;

        case (state_q)
            struct_seq_gen_pkg::ST_IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    mode_d        = struct_seq_gen_pkg::mode_e'(mode);
                    var1_d.first  = nextFirst;
                    var2_d.second = nextSecond;
                    var3_d.third  = nextThird;
                    beat_d        = '0;
                    valid_d       = 1'b1;
                    state_d       = struct_seq_gen_pkg::ST_RUN;
                end
            end

            struct_seq_gen_pkg::ST_RUN: begin
                if (handshake) begin
                    var1_d.first  = nextFirst;
                    var2_d.second = nextSecond;
                    var3_d.third  = nextThird;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = struct_seq_gen_pkg::ST_DONE;
                    end else begin
                        beat_d = beat_q + CW'(1);
                    end
                end
            end

            struct_seq_gen_pkg::ST_DONE: begin
                valid_d = 1'b0;
                state_d = struct_seq_gen_pkg::ST_IDLE;
            end

            default: begin
                valid_d = 1'b0;
                state_d = struct_seq_gen_pkg::ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any burst in progress and clears every output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= struct_seq_gen_pkg::ST_IDLE;
            mode_q  <= struct_seq_gen_pkg::MODE_CONST;
            beat_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            var1_q  <= '0;
            var2_q  <= '0;
            var3_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            var1_q  <= var1_d;
            var2_q  <= var2_d;
            var3_q  <= var3_d;
        end
    end

    assign out_valid = valid_q;
    assign done      = done_q;
    assign var1      = var1_q;
    assign var2      = var2_q;
    assign var3      = var3_q;

endmodule

// File: tb/tb_struct_seq_gen.sv
// Scoreboard bench for struct_seq_gen: four instances with different burst
// lengths share clock and reset; expected records are queued when a burst is
// started and popped as each beat is accepted.

module tb_struct_seq_gen;

    localparam int NDUT = 4;
    localparam int LEN0 = 4;
    localparam int LEN1 = 70;
    localparam int LEN2 = 1;
    localparam int LEN3 = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         startS [NDUT];
    logic [1:0]   modeS  [NDUT];
    logic         readyS [NDUT];
    logic         validS [NDUT];
    logic         doneS  [NDUT];
    pkg1::struct1 v1S    [NDUT];
    pkg2::struct1 v2S    [NDUT];
    logic [5:0]   v3S    [NDUT];

    typedef struct {
        int f1;
        int f2;
        int f3;
    } rec_t;

    rec_t expQ [$];
    rec_t obsQ [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    struct_seq_gen #(.LEN(LEN0), .W3(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(startS[0]), .mode(modeS[0]),
        .out_valid(validS[0]), .out_ready(readyS[0]),
        .var1(v1S[0]), .var2(v2S[0]), .var3(v3S[0]), .done(doneS[0])
    );

    struct_seq_gen #(.LEN(LEN1), .W3(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(startS[1]), .mode(modeS[1]),
        .out_valid(validS[1]), .out_ready(readyS[1]),
        .var1(v1S[1]), .var2(v2S[1]), .var3(v3S[1]), .done(doneS[1])
    );

    struct_seq_gen #(.LEN(LEN2), .W3(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(startS[2]), .mode(modeS[2]),
        .out_valid(validS[2]), .out_ready(readyS[2]),
        .var1(v1S[2]), .var2(v2S[2]), .var3(v3S[2]), .done(doneS[2])
    );

    struct_seq_gen #(.LEN(LEN3), .W3(6)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(startS[3]), .mode(modeS[3]),
        .out_valid(validS[3]), .out_ready(readyS[3]),
        .var1(v1S[3]), .var2(v2S[3]), .var3(v3S[3]), .done(doneS[3])
    );

    // Every comparison lands here so the counters always match what was reported
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int initField(input int w, input logic [1:0] md);
        return (md == 2'd1) ? 0 : ((1 << w) - 1);
    endfunction

    function automatic int stepField(input int v, input int w, input logic [1:0] md);
        int mask;
        mask = (1 << w) - 1;
        case (md)
            2'd1:    return (v + 1) & mask;
            2'd2:    return (v - 1) & mask;
            default: return v;
        endcase
    endfunction

    // Queue the full expected record sequence for one burst
    task automatic pushBurst(input int len, input logic [1:0] md);
        rec_t r;
        r.f1 = initField(8, md);
        r.f2 = initField(7, md);
        r.f3 = initField(6, md);
        for (int b = 0; b < len; b++) begin
            expQ.push_back(r);
            r.f1 = stepField(r.f1, 8, md);
            r.f2 = stepField(r.f2, 7, md);
            r.f3 = stepField(r.f3, 6, md);
        end
    endtask

    // Run one burst on instance sel, optionally stalling one beat, poking start mid-burst, or aborting with reset
    task automatic applyStimulus(input int sel, input int len, input logic [1:0] md,
                                 input int stallBeat, input int stallCycles,
                                 input bit pulseStart, input int abortBeat);
        int   beat;
        int   stall;
        int   cycles;
        bit   aborted;
        rec_t e;
        rec_t o;
        beat    = 0;
        stall   = 0;
        cycles  = 0;
        aborted = 1'b0;
        expQ.delete();
        obsQ.delete();
        pushBurst(len, md);

        startS[sel] = 1'b1;
        modeS[sel]  = md;
        readyS[sel] = 1'b0;
        @(negedge clk);
        startS[sel] = 1'b0;
        checkOutput("validUp", validS[sel], 1);

        while (beat < len && !aborted && cycles < len * 4 + 40) begin
            if (beat == abortBeat) begin
                rst_n = 1'b0;
                #1;
                checkOutput("abortValid", validS[sel], 0);
                checkOutput("abortFirst", v1S[sel].first, 0);
                checkOutput("abortSecond", v2S[sel].second, 0);
                checkOutput("abortThird", v3S[sel], 0);
                checkOutput("abortDone", doneS[sel], 0);
                expQ.delete();
                aborted = 1'b1;
                readyS[sel] = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    checkOutput("abortNoDone", doneS[sel], 0);
                    checkOutput("abortIdle", validS[sel], 0);
                end
            end else begin
                readyS[sel] = !(beat == stallBeat && stall < stallCycles);
                if (pulseStart && beat == 1) begin
                    startS[sel] = 1'b1;
                    modeS[sel]  = ~md;
                end else begin
                    startS[sel] = 1'b0;
                end
                checkOutput("validHi", validS[sel], 1);
                if (!readyS[sel]) begin
                    stall++;
                    e = expQ[0];
                    checkOutput("stallFirst", v1S[sel].first, e.f1);
                    checkOutput("stallSecond", v2S[sel].second, e.f2);
                    checkOutput("stallThird", v3S[sel], e.f3);
                end else if (validS[sel]) begin
                    e = expQ.pop_front();
                    o.f1 = v1S[sel].first;
                    o.f2 = v2S[sel].second;
                    o.f3 = v3S[sel];
                    obsQ.push_back(o);
                    checkOutput("beatFirst", o.f1, e.f1);
                    checkOutput("beatSecond", o.f2, e.f2);
                    checkOutput("beatThird", o.f3, e.f3);
                    beat++;
                end
                @(negedge clk);
                cycles++;
            end
        end

        readyS[sel] = 1'b0;
        startS[sel] = 1'b0;
        if (!aborted) begin
            checkOutput("burstBeats", beat, len);
            checkOutput("doneHi", doneS[sel], 1);
            checkOutput("validLo", validS[sel], 0);
            @(negedge clk);
            checkOutput("doneOnce", doneS[sel], 0);
            checkOutput("idleValid", validS[sel], 0);
            checkOutput("queueEmpty", expQ.size(), 0);
        end
    endtask

    // Test sequence: reset state, then each burst scenario in turn
    initial begin
        for (int i = 0; i < NDUT; i++) begin
            startS[i] = 1'b0;
            modeS[i]  = 2'd0;
            readyS[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput("rstValid", validS[i], 0);
            checkOutput("rstDone", doneS[i], 0);
            checkOutput("rstFirst", v1S[i].first, 0);
            checkOutput("rstThird", v3S[i], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] const burst, LEN=4");
        applyStimulus(0, LEN0, 2'd0, -1, 0, 1'b0, -1);
        if (obsQ.size() == LEN0) begin
            checkOutput("constFirst", obsQ[3].f1, 255);
            checkOutput("constSecond", obsQ[3].f2, 127);
            checkOutput("constThird", obsQ[3].f3, 63);
        end else begin
            checkOutput("constCount", obsQ.size(), LEN0);
        end

        $display("[TB] incr burst with wrap, LEN=70");
        applyStimulus(1, LEN1, 2'd1, -1, 0, 1'b0, -1);
        if (obsQ.size() == LEN1) begin
            checkOutput("wrapThird64", obsQ[64].f3, 0);
            checkOutput("wrapFirst64", obsQ[64].f1, 64);
            checkOutput("wrapSecond64", obsQ[64].f2, 64);
            checkOutput("wrapFirst69", obsQ[69].f1, 69);
            checkOutput("wrapThird69", obsQ[69].f3, 5);
        end else begin
            checkOutput("incrCount", obsQ.size(), LEN1);
        end

        $display("[TB] decr burst with backpressure, LEN=8");
        applyStimulus(3, LEN3, 2'd2, 1, 5, 1'b0, -1);
        if (obsQ.size() == LEN3) begin
            checkOutput("bpFirst1", obsQ[1].f1, 254);
            checkOutput("bpFirst2", obsQ[2].f1, 253);
        end else begin
            checkOutput("bpCount", obsQ.size(), LEN3);
        end

        $display("[TB] start and mode poked during an incr burst, LEN=4");
        applyStimulus(0, LEN0, 2'd1, -1, 0, 1'b1, -1);
        repeat (3) begin
            @(negedge clk);
            checkOutput("noRestart", validS[0], 0);
        end

        $display("[TB] reset abort at beat 3, then fresh burst, LEN=8");
        applyStimulus(3, LEN3, 2'd1, -1, 0, 1'b0, 3);
        applyStimulus(3, LEN3, 2'd1, -1, 0, 1'b0, -1);

        $display("[TB] mode 3 single-record burst, LEN=1");
        applyStimulus(2, LEN2, 2'd3, -1, 0, 1'b0, -1);
        if (obsQ.size() == LEN2) begin
            checkOutput("m3First", obsQ[0].f1, 255);
            checkOutput("m3Second", obsQ[0].f2, 127);
            checkOutput("m3Third", obsQ[0].f3, 63);
        end else begin
            checkOutput("m3Count", obsQ.size(), LEN2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
